// File: rtl/rotate_commit.sv
// Rotation sequencer: latches the active piece, feeds rotate_blocks, then validates the
// returned candidate against playfield bounds and the locked-cell board before committing.
module rotate_commit #(
    parameter int unsigned COLS     = 10,
    parameter int unsigned ROWS     = 20,
    parameter int unsigned CELL_W   = 5,
    parameter int unsigned ORIENT_W = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rot_req,
    input  logic                  rot_left,
    input  logic [4*CELL_W-1:0]   piece_x,
    input  logic [4*CELL_W-1:0]   piece_y,
    input  logic [ORIENT_W-1:0]   piece_orient,
    output logic [4*CELL_W-1:0]   rb_x,
    output logic [4*CELL_W-1:0]   rb_y,
    output logic [ORIENT_W-1:0]   rb_orient,
    output logic                  rb_left,
    input  logic [4*CELL_W-1:0]   cand_x,
    input  logic [4*CELL_W-1:0]   cand_y,
    input  logic [ORIENT_W-1:0]   cand_orient,
    output logic                  brd_rd_en,
    output logic [CELL_W-1:0]     brd_rd_x,
    output logic [CELL_W-1:0]     brd_rd_y,
    input  logic                  brd_occ,
    output logic                  busy,
    output logic                  done,
    output logic                  accepted,
    output logic [4*CELL_W-1:0]   out_x,
    output logic [4*CELL_W-1:0]   out_y,
    output logic [ORIENT_W-1:0]   out_orient
);

    localparam int unsigned XY_W = 4 * CELL_W;
    localparam logic [CELL_W-1:0] COLS_LIM = CELL_W'(COLS);
    localparam logic [CELL_W-1:0] ROWS_LIM = CELL_W'(ROWS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]          state, state_d;
    logic [1:0]          cnt, cnt_d, cnt_inc;
    logic                hit, hit_d, hit_fin;
    logic [XY_W-1:0]     cand_x_r, cand_x_d, cand_y_r, cand_y_d;
    logic [ORIENT_W-1:0] cand_o_r, cand_o_d;
    logic [XY_W-1:0]     rb_x_d, rb_y_d, out_x_d, out_y_d;
    logic [ORIENT_W-1:0] rb_orient_d, out_orient_d;
    logic                rb_left_d, rd_en_d, busy_d, done_d, acc_d;
    logic [CELL_W-1:0]   rd_x_d, rd_y_d;
    logic                oob;

    // Any candidate cell outside the playfield rejects the rotation outright.
    always_comb begin
        oob = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cand_x[i*CELL_W +: CELL_W] >= COLS_LIM || cand_y[i*CELL_W +: CELL_W] >= ROWS_LIM)
                oob = 1'b1;
        end
    end

    assign cnt_inc = cnt + 2'd1;
    assign hit_fin = hit | brd_occ;

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        hit_d        = hit;
        cand_x_d     = cand_x_r;
        cand_y_d     = cand_y_r;
        cand_o_d     = cand_o_r;
        rb_x_d       = rb_x;
        rb_y_d       = rb_y;
        rb_orient_d  = rb_orient;
        rb_left_d    = rb_left;
        rd_en_d      = 1'b0;
        rd_x_d       = brd_rd_x;
        rd_y_d       = brd_rd_y;
        done_d       = 1'b0;
        acc_d        = 1'b0;
        out_x_d      = out_x;
        out_y_d      = out_y;
        out_orient_d = out_orient;

        case (state)
            S_IDLE: begin
                if (rot_req) begin
                    rb_x_d      = piece_x;
                    rb_y_d      = piece_y;
                    rb_orient_d = piece_orient;
                    rb_left_d   = rot_left;
                    state_d     = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                cand_x_d = cand_x;
                cand_y_d = cand_y;
                cand_o_d = cand_orient;
                hit_d    = 1'b0;
                if (oob) begin
                    state_d      = S_DONE;
                    done_d       = 1'b1;
                    out_x_d      = rb_x;
                    out_y_d      = rb_y;
                    out_orient_d = rb_orient;
                end else begin
                    // First board read goes out straight from the live candidate.
                    state_d = S_CHECK;
                    cnt_d   = 2'd0;
                    rd_en_d = 1'b1;
                    rd_x_d  = cand_x[CELL_W-1:0];
                    rd_y_d  = cand_y[CELL_W-1:0];
                end
            end
            S_CHECK: begin
                // Occupancy lags its read by one cycle, so cnt=0 has nothing to fold in yet.
                if (cnt != 2'd0)
                    hit_d = hit | brd_occ;
                if (cnt == 2'd3) begin
                    state_d = S_WAIT;
                end else begin
                    cnt_d   = cnt_inc;
                    rd_en_d = 1'b1;
                    rd_x_d  = cand_x_r[int'(cnt_inc)*CELL_W +: CELL_W];
                    rd_y_d  = cand_y_r[int'(cnt_inc)*CELL_W +: CELL_W];
                end
            end
            S_WAIT: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                hit_d   = hit_fin;
                if (hit_fin) begin
                    out_x_d      = rb_x;
                    out_y_d      = rb_y;
                    out_orient_d = rb_orient;
                end else begin
                    acc_d        = 1'b1;
                    out_x_d      = cand_x_r;
                    out_y_d      = cand_y_r;
                    out_orient_d = cand_o_r;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= 2'd0;
            hit        <= 1'b0;
            cand_x_r   <= '0;
            cand_y_r   <= '0;
            cand_o_r   <= '0;
            rb_x       <= '0;
            rb_y       <= '0;
            rb_orient  <= '0;
            rb_left    <= 1'b0;
            brd_rd_en  <= 1'b0;
            brd_rd_x   <= '0;
            brd_rd_y   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            accepted   <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_orient <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            hit        <= hit_d;
            cand_x_r   <= cand_x_d;
            cand_y_r   <= cand_y_d;
            cand_o_r   <= cand_o_d;
            rb_x       <= rb_x_d;
            rb_y       <= rb_y_d;
            rb_orient  <= rb_orient_d;
            rb_left    <= rb_left_d;
            brd_rd_en  <= rd_en_d;
            brd_rd_x   <= rd_x_d;
            brd_rd_y   <= rd_y_d;
            busy       <= busy_d;
            done       <= done_d;
            accepted   <= acc_d;
            out_x      <= out_x_d;
            out_y      <= out_y_d;
            out_orient <= out_orient_d;
        end
    end

endmodule
